mem_wb_stage: RTL and testbench

Parametrised, elastic MEM/WB pipeline stage for the RV32IM core. It replaces the fixed-width, always-advancing MEM/WB register with a valid/ready handshaked stage that supports back-pressure, flush and an optional 2-entry skid buffer. It also produces the final write-back data and write-back controls, and counts retired register writes. It sits between the data-memory stage and the register file.

---
 rtl/mem_wb_stage.sv | 148 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Elastic MEM/WB stage: valid/ready handshake with optional 2-entry skid buffer,
// write-back data select, x0 write suppression and retired-write counter.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SKID   = 1,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic              in_mem_to_reg,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_alu_data,
  input  logic [ADDR_W-1:0] in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wen,
  output logic [ADDR_W-1:0] out_rd,
  output logic [DATA_W-1:0] out_wb_data,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [DATA_W-1:0] out_alu_data,
  output logic [CNT_W-1:0]  retire_count,
  output logic [1:0]        occupancy
);

  localparam int ENT_W = 2 + 2 * DATA_W + ADDR_W;

  // Entry layout: {wen, mem_to_reg, mem_data, alu_data, rd}
  logic             r_m_valid;
  logic [ENT_W-1:0] r_m_ent;
  logic             r_s_valid;
  logic [ENT_W-1:0] r_s_ent;
  logic [1:0]       r_occ;
  logic [CNT_W-1:0] r_retire;

  logic             w_m_valid_next;
  logic [ENT_W-1:0] w_m_ent_next;
  logic             w_s_valid_next;
  logic [ENT_W-1:0] w_s_ent_next;
  logic [1:0]       w_occ_next;
  logic [CNT_W-1:0] w_retire_next;

  logic [ENT_W-1:0] w_in_ent;
  logic             w_accept;
  logic             w_pop;
  logic             w_m_wen;
  logic             w_m_m2r;
  logic [DATA_W-1:0] w_m_mem;
  logic [DATA_W-1:0] w_m_alu;
  logic [ADDR_W-1:0] w_m_rd;
  logic             w_out_wen;

  assign w_in_ent = {in_wen, in_mem_to_reg, in_mem_data, in_alu_data, in_rd};
  assign {w_m_wen, w_m_m2r, w_m_mem, w_m_alu, w_m_rd} = r_m_ent;

  generate
    if (SKID != 0) begin : g_skid
      // Ready depends only on skid occupancy, so it is a pure register output.
      assign in_ready = !r_s_valid;
    end else begin : g_single
      assign in_ready = !r_m_valid || out_ready;
    end
  endgenerate

  assign w_accept  = in_valid && in_ready;
  assign w_pop     = r_m_valid && out_ready;
  assign w_out_wen = r_m_valid && w_m_wen && (w_m_rd != '0);

  always_comb begin
    w_m_valid_next = r_m_valid;
    w_m_ent_next   = r_m_ent;
    w_s_valid_next = r_s_valid;
    w_s_ent_next   = r_s_ent;
    if (SKID != 0) begin
      case ({r_s_valid, r_m_valid})
        2'b00: begin
          if (w_accept) begin
            w_m_valid_next = 1'b1;
            w_m_ent_next   = w_in_ent;
          end
        end
        2'b01: begin
          if (w_accept && w_pop) begin
            w_m_ent_next = w_in_ent;
          end else if (w_accept) begin
            w_s_valid_next = 1'b1;
            w_s_ent_next   = w_in_ent;
          end else if (w_pop) begin
            w_m_valid_next = 1'b0;
          end
        end
        default: begin
          if (w_pop) begin
            w_m_ent_next   = r_s_ent;
            w_s_valid_next = 1'b0;
          end
        end
      endcase
    end else begin
      if (w_accept) begin
        w_m_valid_next = 1'b1;
        w_m_ent_next   = w_in_ent;
      end else if (w_pop) begin
        w_m_valid_next = 1'b0;
      end
    end
    // Flush kills valid bits only; payload is left as-is.
    if (flush) begin
      w_m_valid_next = 1'b0;
      w_s_valid_next = 1'b0;
    end
  end

  assign w_occ_next    = {1'b0, w_m_valid_next} + {1'b0, w_s_valid_next};
  assign w_retire_next = (w_pop && w_out_wen && !flush) ? r_retire + CNT_W'(1) : r_retire;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_m_valid <= 1'b0;
      r_m_ent   <= '0;
      r_s_valid <= 1'b0;
      r_s_ent   <= '0;
      r_occ     <= 2'd0;
      r_retire  <= '0;
    end else begin
      r_m_valid <= w_m_valid_next;
      r_m_ent   <= w_m_ent_next;
      r_s_valid <= w_s_valid_next;
      r_s_ent   <= w_s_ent_next;
      r_occ     <= w_occ_next;
      r_retire  <= w_retire_next;
    end
  end

  assign out_valid    = r_m_valid;
  assign out_wen      = w_out_wen;
  assign out_rd       = w_m_rd;
  assign out_wb_data  = w_m_m2r ? w_m_mem : w_m_alu;
  assign out_mem_data = w_m_mem;
  assign out_alu_data = w_m_alu;
  assign retire_count = r_retire;
  assign occupancy    = r_occ;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: a SKID=1 instance and a SKID=0 instance (4-bit counter)
// driven in lockstep and checked against queue-based reference models.
module tb_mem_wb_stage;

  logic        CLK = 1'b0;
  logic        Reset, flush, in_valid, in_wen, in_mem_to_reg, out_ready;
  logic [31:0] in_mem_data, in_alu_data;
  logic [4:0]  in_rd;

  logic        in_ready_a, out_valid_a, out_wen_a;
  logic [4:0]  out_rd_a;
  logic [31:0] wb_a, mem_a, alu_a, retire_a;
  logic [1:0]  occ_a;

  logic        in_ready_b, out_valid_b, out_wen_b;
  logic [4:0]  out_rd_b;
  logic [31:0] wb_b, mem_b, alu_b;
  logic [3:0]  retire_b;
  logic [1:0]  occ_b;

  always #5 CLK = ~CLK;

  mem_wb_stage #(.DATA_W(32), .ADDR_W(5), .SKID(1), .CNT_W(32)) u_a (
    .CLK(CLK), .Reset(Reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_wen(in_wen),
    .in_mem_to_reg(in_mem_to_reg), .in_mem_data(in_mem_data),
    .in_alu_data(in_alu_data), .in_rd(in_rd),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_wen(out_wen_a),
    .out_rd(out_rd_a), .out_wb_data(wb_a), .out_mem_data(mem_a),
    .out_alu_data(alu_a), .retire_count(retire_a), .occupancy(occ_a)
  );

  mem_wb_stage #(.DATA_W(32), .ADDR_W(5), .SKID(0), .CNT_W(4)) u_b (
    .CLK(CLK), .Reset(Reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_wen(in_wen),
    .in_mem_to_reg(in_mem_to_reg), .in_mem_data(in_mem_data),
    .in_alu_data(in_alu_data), .in_rd(in_rd),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_wen(out_wen_b),
    .out_rd(out_rd_b), .out_wb_data(wb_b), .out_mem_data(mem_b),
    .out_alu_data(alu_b), .retire_count(retire_b), .occupancy(occ_b)
  );

  typedef struct {
    logic        wen;
    logic        m2r;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [4:0]  rd;
  } ent_t;

  // Reference model: a FIFO of entries per instance plus a retire count.
  ent_t        qa[$];
  ent_t        qb[$];
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_step   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string p, input int sz, input ent_t h, input logic [31:0] cnt_exp,
                         input logic ov, input logic ow, input logic [4:0] ord,
                         input logic [31:0] wb, input logic [31:0] mem, input logic [31:0] alu,
                         input logic [31:0] cnt_obs, input logic [1:0] occ);
    chk({p, ".out_valid"}, 64'(ov), 64'(sz > 0));
    chk({p, ".occupancy"}, 64'(occ), 64'(sz));
    chk({p, ".retire_count"}, 64'(cnt_obs), 64'(cnt_exp));
    if (sz > 0) begin
      chk({p, ".out_rd"}, 64'(ord), 64'(h.rd));
      chk({p, ".out_wb_data"}, 64'(wb), 64'(h.m2r ? h.mem : h.alu));
      chk({p, ".out_wen"}, 64'(ow), 64'(h.wen && (h.rd != 5'd0)));
      chk({p, ".out_mem_data"}, 64'(mem), 64'(h.mem));
      chk({p, ".out_alu_data"}, 64'(alu), 64'(h.alu));
    end else begin
      chk({p, ".out_wen_idle"}, 64'(ow), 64'(0));
    end
  endtask

  task automatic check_all();
    ent_t ha;
    ent_t hb;
    ha = '{wen: 1'b0, m2r: 1'b0, mem: 32'd0, alu: 32'd0, rd: 5'd0};
    hb = ha;
    if (qa.size() > 0) ha = qa[0];
    if (qb.size() > 0) hb = qb[0];
    chk_out("A", qa.size(), ha, cnt_a, out_valid_a, out_wen_a, out_rd_a, wb_a, mem_a, alu_a,
            retire_a, occ_a);
    chk_out("B", qb.size(), hb, {28'd0, cnt_b}, out_valid_b, out_wen_b, out_rd_b, wb_b, mem_b,
            alu_b, {28'd0, retire_b}, occ_b);
  endtask

  task automatic do_reset();
    Reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_wen = 1'b1; in_mem_to_reg = 1'b1;
    in_mem_data = 32'hFFFF_FFFF; in_alu_data = 32'hFFFF_FFFF; in_rd = 5'h1F; out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    Reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_wen = 1'b0; in_mem_to_reg = 1'b0;
    in_mem_data = 32'd0; in_alu_data = 32'd0; in_rd = 5'd0; out_ready = 1'b0;
    qa.delete(); qb.delete(); cnt_a = 32'd0; cnt_b = 4'd0;
    #1;
    chk("rst.A.in_ready", 64'(in_ready_a), 64'(1));
    chk("rst.B.in_ready", 64'(in_ready_b), 64'(1));
    chk("rst.A.out_wb_data", 64'(wb_a), 64'(0));
    chk("rst.A.out_rd", 64'(out_rd_a), 64'(0));
    chk("rst.B.out_wb_data", 64'(wb_b), 64'(0));
    chk("rst.B.out_rd", 64'(out_rd_b), 64'(0));
    check_all();
    $display("reset released: occA=%0d occB=%0d", occ_a, occ_b);
  endtask

  task automatic step(input logic v, input logic wen, input logic m2r, input logic [31:0] mem,
                      input logic [31:0] alu, input logic [4:0] rd, input logic ordy,
                      input logic fl);
    logic ra, rb;
    ent_t e;
    in_valid = v; in_wen = wen; in_mem_to_reg = m2r; in_mem_data = mem;
    in_alu_data = alu; in_rd = rd; out_ready = ordy; flush = fl;
    #1;
    ra = (qa.size() < 2);
    rb = (qb.size() == 0) || ordy;
    chk("A.in_ready", 64'(in_ready_a), 64'(ra));
    chk("B.in_ready", 64'(in_ready_b), 64'(rb));
    e = '{wen: wen, m2r: m2r, mem: mem, alu: alu, rd: rd};
    @(posedge CLK);
    if (fl) begin
      qa.delete();
      qb.delete();
    end else begin
      if (qa.size() > 0 && ordy) begin
        if (qa[0].wen && qa[0].rd != 5'd0) cnt_a = cnt_a + 32'd1;
        void'(qa.pop_front());
      end
      if (v && ra) qa.push_back(e);
      if (qb.size() > 0 && ordy) begin
        if (qb[0].wen && qb[0].rd != 5'd0) cnt_b = cnt_b + 4'd1;
        void'(qb.pop_front());
      end
      if (v && rb) qb.push_back(e);
    end
    #1;
    check_all();
    n_step++;
    $display("step %0d v=%0b rd=%0d ordy=%0b fl=%0b occA=%0d occB=%0d retA=%0d retB=%0d",
             n_step, v, rd, ordy, fl, occ_a, occ_b, retire_a, retire_b);
  endtask

  initial begin
    logic [31:0] saved_a;
    logic [3:0]  saved_b;
    do_reset();

    // Stream four entries at full throughput.
    for (int i = 1; i <= 4; i++)
      step(1'b1, 1'b1, 1'b0, 32'd0, 32'(i * 32'h11), 5'(i), 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
    chk("stream.A.retire", 64'(retire_a), 64'(4));
    chk("stream.B.retire", 64'(retire_b), 64'(4));

    // Back-pressure: the skid instance takes exactly two.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b0, 32'd0, 32'(32'hA1 + i), 5'(5 + i), 1'b0, 1'b0);
    chk("bp.A.occupancy", 64'(occ_a), 64'(2));
    chk("bp.A.in_ready", 64'(in_ready_a), 64'(0));
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
    chk("bp.A.in_ready_back", 64'(in_ready_a), 64'(1));

    // Memory-data select, then a write to x0 that must not retire.
    step(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h100, 5'd9, 1'b0, 1'b0);
    chk("m2r.A.wb", 64'(wb_a), 64'h0000_0000_DEAD_BEEF);
    step(1'b1, 1'b1, 1'b0, 32'd0, 32'h55, 5'd0, 1'b1, 1'b0);
    chk("x0.A.out_wen", 64'(out_wen_a), 64'(0));
    saved_a = cnt_a;
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
    chk("x0.A.retire", 64'(retire_a), 64'(saved_a));

    // Fill the skid instance, then flush with a new entry offered and a pop pending.
    step(1'b1, 1'b1, 1'b0, 32'd0, 32'h71, 5'd3, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'd0, 32'h72, 5'd4, 1'b0, 1'b0);
    saved_a = cnt_a;
    saved_b = cnt_b;
    step(1'b1, 1'b1, 1'b0, 32'd0, 32'h73, 5'd6, 1'b1, 1'b1);
    chk("flush.A.out_valid", 64'(out_valid_a), 64'(0));
    chk("flush.A.occupancy", 64'(occ_a), 64'(0));
    chk("flush.A.retire", 64'(retire_a), 64'(saved_a));
    chk("flush.B.retire", 64'(retire_b), 64'(saved_b));

    // Single-register mode: ready follows out_ready combinationally.
    step(1'b1, 1'b1, 1'b0, 32'd0, 32'h81, 5'd8, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'd0, 32'h82, 5'd10, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'd0, 32'h83, 5'd11, 1'b1, 1'b0);
    chk("s0.B.replacement_rd", 64'(out_rd_b), 64'(11));

    // Randomised traffic with a mid-run reset.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] rd;
      if (i == 300) do_reset();
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), $urandom, $urandom, rd,
           $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
